// File: rtl/servo_pkg.sv
// Shared constants and FSM state encoding for the servo PWM generator.
package servo_pkg;

    localparam int CNT_W_DEF  = 16;
    localparam int TICKS_20MS = 20000;
    localparam int TICKS_1MS  = 1000;
    localparam int TICKS_2MS  = 2000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/servo_pwm_ch.sv
// One servo channel: clamped shadow width register and registered PWM comparator.
module servo_pwm_ch #(
    parameter int CNT_W = 16
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] lo,
    input  logic [CNT_W-1:0] hi,
    input  logic             load,
    input  logic             run,
    output logic             pwm
);
    logic [CNT_W-1:0] sh_width;
    logic [CNT_W-1:0] clamped;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    // Applying the upper bound last lets cfg_max win when the limits are inverted.
    always_comb begin
        clamped = width;
        if (width < lo) clamped = lo;
        if (clamped > hi) clamped = hi;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            sh_width <= '0;
            pwm      <= 1'b0;
        end else begin
            if (load) sh_width <= clamped;
            pwm <= run && (cnt < sh_width);
        end
    end

endmodule

// File: rtl/servo_pwm_gen.sv
// Multi-channel servo PWM generator: prescaler, frame counter, update handshake and
// enable FSM; pulse widths are double-buffered and only change at frame boundaries.
module servo_pwm_gen
    import servo_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int PRESCALE = 100
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    cfg_enable,
    input  logic [CNT_W-1:0]        cfg_period,
    input  logic [CNT_W-1:0]        cfg_min,
    input  logic [CNT_W-1:0]        cfg_max,
    input  logic [NUM_CH*CNT_W-1:0] cfg_width,
    input  logic                    cfg_update,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic                    frame_start,
    output logic                    upd_pending
);
    localparam int               PRE_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(PRESCALE - 1);
    localparam logic [PRE_W-1:0] PRE_ONE    = PRE_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] PERIOD_MIN = CNT_W'(2);

    state_t           state, state_d;
    logic [PRE_W-1:0] pre;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] sh_period;
    logic             active;
    logic             period_ok;
    logic             tick;
    logic             wrap;
    logic             load;

    always_comb begin
        state_d   = state;
        load      = 1'b0;
        active    = (state == ST_RUN) && cfg_enable;
        period_ok = (sh_period >= PERIOD_MIN);
        tick      = active && (pre == PRE_LAST);
        wrap      = tick && period_ok && (cnt == sh_period - CNT_ONE);
        unique case (state)
            ST_IDLE: begin
                if (cfg_enable) begin
                    state_d = ST_RUN;
                    load    = 1'b1;
                end
            end
            ST_RUN: begin
                if (!cfg_enable) begin
                    state_d = ST_IDLE;
                end else if (upd_pending && (wrap || !period_ok)) begin
                    // A degenerate period has no frame boundary, so apply at once.
                    load = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) state <= ST_IDLE;
        else          state <= state_d;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pre         <= '0;
            cnt         <= '0;
            sh_period   <= '0;
            upd_pending <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            if (!active) begin
                pre <= '0;
                cnt <= '0;
            end else begin
                pre <= tick ? '0 : pre + PRE_ONE;
                if (tick) cnt <= (wrap || !period_ok) ? '0 : cnt + CNT_ONE;
            end
            if (load) sh_period <= cfg_period;
            // A strobe landing on a load keeps the flag so the next boundary reloads.
            if (cfg_update) upd_pending <= 1'b1;
            else if (load)  upd_pending <= 1'b0;
            frame_start <= wrap ||
                           ((state == ST_IDLE) && cfg_enable && (cfg_period >= PERIOD_MIN));
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        servo_pwm_ch #(.CNT_W(CNT_W)) u_ch (
            .ACLK    (ACLK),
            .ARESETN (ARESETN),
            .cnt     (cnt),
            .width   (cfg_width[i*CNT_W +: CNT_W]),
            .lo      (cfg_min),
            .hi      (cfg_max),
            .load    (load),
            .run     (active && period_ok),
            .pwm     (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Self-checking bench for servo_pwm_gen: vector table, hand-written corner sequences
// and randomized configurations compared against an arithmetic frame model.
module tb_servo_pwm_gen;
    localparam int NUM_CH   = 4;
    localparam int CNT_W    = 16;
    localparam int PRESCALE = 2;

    typedef logic [NUM_CH-1:0][CNT_W-1:0] wvec_t;

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] mn;
        logic [CNT_W-1:0] mx;
        wvec_t            w;
        wvec_t            exp_hi;
        logic [7:0]       exp_fs;
    } vec_t;

    logic                    ACLK = 1'b0;
    logic                    ARESETN = 1'b1;
    logic                    cfg_enable = 1'b0;
    logic                    cfg_update = 1'b0;
    logic [CNT_W-1:0]        cfg_period = '0;
    logic [CNT_W-1:0]        cfg_min = '0;
    logic [CNT_W-1:0]        cfg_max = '0;
    logic [NUM_CH*CNT_W-1:0] cfg_width = '0;
    logic [NUM_CH-1:0]       pwm_out;
    logic                    frame_start;
    logic                    upd_pending;

    int checks = 0;
    int errors = 0;
    int k = 0;
    int hi_cnt [NUM_CH];
    int fs_cnt;
    int fr [4];
    vec_t vecs [7];

    servo_pwm_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESCALE(PRESCALE)) dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .cfg_enable  (cfg_enable),
        .cfg_period  (cfg_period),
        .cfg_min     (cfg_min),
        .cfg_max     (cfg_max),
        .cfg_width   (cfg_width),
        .cfg_update  (cfg_update),
        .pwm_out     (pwm_out),
        .frame_start (frame_start),
        .upd_pending (upd_pending)
    );

    always #10 ACLK = ~ACLK;

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at k=%0d", k);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s k=%0d actual=%0d expected=%0d", name, k, act, exp);
        end
    endtask

    function automatic wvec_t mkw(input int w0, input int w1, input int w2, input int w3);
        wvec_t r;
        r[0] = CNT_W'(w0);
        r[1] = CNT_W'(w1);
        r[2] = CNT_W'(w2);
        r[3] = CNT_W'(w3);
        return r;
    endfunction

    function automatic vec_t mkv(input int p, input int mn, input int mx, input wvec_t w,
                                 input wvec_t e, input int fs);
        vec_t v;
        v.period = CNT_W'(p);
        v.mn     = CNT_W'(mn);
        v.mx     = CNT_W'(mx);
        v.w      = w;
        v.exp_hi = e;
        v.exp_fs = 8'(fs);
        return v;
    endfunction

    function automatic int ref_clamp(input int w, input int mn, input int mx);
        if (mn > mx) return mx;
        if (w < mn) return mn;
        if (w > mx) return mx;
        return w;
    endfunction

    task automatic step();
        @(posedge ACLK);
        #1;
        k++;
    endtask

    task automatic set_w(input int ch, input int val);
        cfg_width[ch*CNT_W +: CNT_W] = CNT_W'(val);
    endtask

    // Leaves the DUT one cycle into RUN with k=0 on the enabling edge.
    task automatic start(input int p, input int mn, input int mx, input wvec_t w);
        cfg_enable = 1'b0;
        step();
        cfg_period = CNT_W'(p);
        cfg_min    = CNT_W'(mn);
        cfg_max    = CNT_W'(mx);
        for (int i = 0; i < NUM_CH; i++) set_w(i, int'(w[i]));
        cfg_enable = 1'b1;
        step();
        k = 0;
        check("enable_fs", {31'd0, frame_start}, (p >= 2) ? 32'd1 : 32'd0);
        check("enable_pwm", {28'd0, pwm_out}, 32'd0);
    endtask

    task automatic measure(input int n);
        for (int i = 0; i < NUM_CH; i++) hi_cnt[i] = 0;
        fs_cnt = 0;
        repeat (n) begin
            step();
            for (int i = 0; i < NUM_CH; i++) if (pwm_out[i]) hi_cnt[i]++;
            if (frame_start) fs_cnt++;
        end
    endtask

    initial begin
        vecs[0] = mkv(10, 0, 10, mkw(1, 3, 5, 0),    mkw(2, 6, 10, 0),    1);
        vecs[1] = mkv(10, 2, 6,  mkw(0, 1, 9, 15),   mkw(4, 4, 12, 12),   1);
        vecs[2] = mkv(10, 0, 20, mkw(10, 12, 0, 10), mkw(20, 20, 0, 20),  1);
        vecs[3] = mkv(1,  0, 10, mkw(5, 5, 5, 5),    mkw(0, 0, 0, 0),     0);
        vecs[4] = mkv(0,  0, 10, mkw(5, 5, 5, 5),    mkw(0, 0, 0, 0),     0);
        vecs[5] = mkv(10, 8, 3,  mkw(0, 5, 9, 1),    mkw(6, 6, 6, 6),     1);
        vecs[6] = mkv(2,  0, 5,  mkw(1, 2, 0, 1),    mkw(2, 4, 0, 2),     1);

        // Asynchronous reset from power-up, then idle with enable low.
        #2 ARESETN = 1'b0;
        #13;
        check("rst_pwm", {28'd0, pwm_out}, 32'd0);
        check("rst_fs", {31'd0, frame_start}, 32'd0);
        check("rst_pend", {31'd0, upd_pending}, 32'd0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (4) begin
            step();
            check("idle_pwm", {28'd0, pwm_out}, 32'd0);
            check("idle_fs", {31'd0, frame_start}, 32'd0);
        end

        // Reset asserted mid-pulse with an update pending.
        start(10, 0, 10, mkw(1, 3, 5, 0));
        step();
        cfg_update = 1'b1;
        step();
        cfg_update = 1'b0;
        step();
        check("pre_rst_pwm", {28'd0, pwm_out}, 32'h6);
        check("pre_rst_pend", {31'd0, upd_pending}, 32'd1);
        #5 ARESETN = 1'b0;
        #1;
        check("async_rst_pwm", {28'd0, pwm_out}, 32'd0);
        check("async_rst_pend", {31'd0, upd_pending}, 32'd0);
        check("async_rst_fs", {31'd0, frame_start}, 32'd0);
        cfg_enable = 1'b0;
        @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (4) begin
            step();
            check("post_rst_pwm", {28'd0, pwm_out}, 32'd0);
            check("post_rst_fs", {31'd0, frame_start}, 32'd0);
        end

        // Vector table: one frame of high-time counts per channel.
        for (int v = 0; v < 7; v++) begin
            start(int'(vecs[v].period), int'(vecs[v].mn), int'(vecs[v].mx), vecs[v].w);
            measure((vecs[v].period >= 2) ? int'(vecs[v].period) * PRESCALE : 20);
            for (int i = 0; i < NUM_CH; i++)
                check($sformatf("vec%0d_hi%0d", v, i), hi_cnt[i], int'(vecs[v].exp_hi[i]));
            check($sformatf("vec%0d_fs", v), fs_cnt, int'(vecs[v].exp_fs));
        end

        // Double buffering: ch1 rewritten at cnt=4 only changes the next frame.
        start(10, 0, 10, mkw(1, 3, 5, 0));
        for (int i = 0; i < 4; i++) fr[i] = 0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (pwm_out[1]) fr[(k - 1) / 20]++;
            if (k == 9 || k == 19) check("dbuf_pend_set", {31'd0, upd_pending}, 32'd1);
            if (k == 20) check("dbuf_pend_clr", {31'd0, upd_pending}, 32'd0);
            cfg_update = (k == 8);
            if (k == 8) set_w(1, 7);
        end
        check("dbuf_old_frame", fr[0], 6);
        check("dbuf_new_frame", fr[1], 14);

        // Update strobes coinciding with the wrap tick.
        start(10, 0, 10, mkw(1, 3, 5, 0));
        for (int i = 0; i < 4; i++) fr[i] = 0;
        for (int c = 1; c <= 80; c++) begin
            step();
            if (pwm_out[0]) fr[(k - 1) / 20]++;
            if (k == 20 || k == 60) check("coinc_pend_set", {31'd0, upd_pending}, 32'd1);
            if (k == 40 || k == 80) check("coinc_pend_clr", {31'd0, upd_pending}, 32'd0);
            cfg_update = (k == 19 || k == 45 || k == 59);
            if (k == 19) set_w(0, 4);
            if (k == 45) set_w(0, 2);
            if (k == 59) set_w(0, 3);
        end
        check("coinc_f0", fr[0], 2);
        check("coinc_f1", fr[1], 2);
        check("coinc_f2", fr[2], 8);
        check("coinc_f3", fr[3], 6);

        // Pending update while the period is degenerate applies without a frame boundary.
        start(1, 0, 10, mkw(1, 3, 5, 0));
        cfg_period = CNT_W'(10);
        cfg_update = 1'b1;
        step();
        cfg_update = 1'b0;
        check("short_pend_set", {31'd0, upd_pending}, 32'd1);
        step();
        check("short_pend_clr", {31'd0, upd_pending}, 32'd0);
        measure(20);
        check("short_hi0", hi_cnt[0], 2);
        check("short_hi1", hi_cnt[1], 6);
        check("short_hi2", hi_cnt[2], 10);
        check("short_hi3", hi_cnt[3], 0);
        check("short_fs", fs_cnt, 1);

        // Disable mid-pulse, then re-enable with new values.
        start(10, 0, 10, mkw(1, 3, 5, 0));
        repeat (3) step();
        check("dis_before", {28'd0, pwm_out}, 32'h6);
        cfg_enable = 1'b0;
        step();
        check("dis_pwm", {28'd0, pwm_out}, 32'd0);
        check("dis_fs", {31'd0, frame_start}, 32'd0);
        repeat (3) begin
            step();
            check("dis_hold", {28'd0, pwm_out}, 32'd0);
        end
        start(6, 0, 10, mkw(2, 1, 6, 0));
        measure(12);
        check("reen_hi0", hi_cnt[0], 4);
        check("reen_hi1", hi_cnt[1], 2);
        check("reen_hi2", hi_cnt[2], 12);
        check("reen_hi3", hi_cnt[3], 0);
        check("reen_fs", fs_cnt, 1);

        // Random configurations against the closed-form frame model.
        for (int r = 0; r < 10; r++) begin
            int p, mn, mx, fl, n;
            int rw [NUM_CH];
            int cw [NUM_CH];
            logic [NUM_CH-1:0] ev;
            logic ef;
            p  = int'($urandom_range(0, 12));
            mn = int'($urandom_range(0, 14));
            mx = int'($urandom_range(0, 14));
            for (int i = 0; i < NUM_CH; i++) begin
                rw[i] = int'($urandom_range(0, 15));
                cw[i] = ref_clamp(rw[i], mn, mx);
            end
            start(p, mn, mx, mkw(rw[0], rw[1], rw[2], rw[3]));
            fl = p * PRESCALE;
            n  = (p >= 2) ? 3 * fl : 20;
            for (int c = 1; c <= n; c++) begin
                step();
                for (int i = 0; i < NUM_CH; i++)
                    ev[i] = (p >= 2) && (((k - 1) % fl) < cw[i] * PRESCALE);
                ef = (p >= 2) && ((k % fl) == 0);
                check($sformatf("rand%0d_pwm", r), {28'd0, pwm_out}, {28'd0, ev});
                check($sformatf("rand%0d_fs", r), {31'd0, frame_start}, {31'd0, ef});
            end
        end

        cfg_enable = 1'b0;
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
